// File: rtl/memory_pkg.sv
// memory_pkg: shared definitions for frame-buffer arbiter clients
// (default address width, arbiter data width, fetch FSM state type).
package memory_pkg;

  localparam int ADDRESS_WIDTH_DEFAULT = 25;
  localparam int DATA_WIDTH            = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: first-word-fall-through buffer with occupancy count and a
// synchronous flush that empties it in one cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  // a push into a full buffer is legal only when the head leaves in the same cycle
  always_comb begin
    pop_ok_s  = pop_i && (count_q != '0);
    push_ok_s = push_i && ((count_q != FULL_CNT) || pop_ok_s);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

endmodule

// File: rtl/frame_fetch.sv
// frame_fetch: credit-limited sequential byte reader feeding the LED scan driver.
// Define FRAME_FETCH_LOOP_EN for continuous frame refresh until abort.
module frame_fetch
  import memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int BUF_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [ADDRESS_WIDTH-1:0] frame_length,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     wr,
  output logic [DATA_WIDTH-1:0]    data_in,
  output logic                     data_in_ready,
  input  logic                     fifo_full,
  input  logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     data_out_ready,
  output logic [DATA_WIDTH-1:0]    pixel_data,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int                       CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]              DEPTH_C = (CW+1)'(BUF_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LEN_ONE = ADDRESS_WIDTH'(1);

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [ADDRESS_WIDTH-1:0] index_q, index_d;
  logic [ADDRESS_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [CW-1:0]            outstanding_q, outstanding_d;
  logic                     req_q, req_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
`ifdef FRAME_FETCH_LOOP_EN
  logic [ADDRESS_WIDTH-1:0] len_q;
`endif

  logic [CW-1:0] buf_count_s;
  logic          buf_empty_s;
  logic          start_ok_s, issue_s, ret_ok_s, pop_s, pixel_valid_s, drain_end_s;

  // credits: in-flight reads plus held bytes never exceed the buffer depth
  always_comb begin
    start_ok_s    = (state_q == ST_IDLE) && start;
    ret_ok_s      = data_out_ready && (outstanding_q != '0);
    pixel_valid_s = !buf_empty_s && (state_q != ST_FLUSH);
    pop_s         = pixel_valid_s && pixel_ready;
    issue_s       = (state_q == ST_FETCH) && !abort && !fifo_full && (remaining_q != '0) &&
                    (({1'b0, outstanding_q} + {1'b0, buf_count_s}) < DEPTH_C);
    drain_end_s   = (state_q == ST_DRAIN) && (outstanding_q == '0) &&
                    ((buf_count_s == '0) || ((buf_count_s == CW'(1)) && pop_s));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = (start && (frame_length != '0)) ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_FLUSH;
        end else if ((remaining_q == '0) || (issue_s && (remaining_q == LEN_ONE))) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_FLUSH;
        end else if (drain_end_s) begin
`ifdef FRAME_FETCH_LOOP_EN
          state_d = ST_FETCH;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: state_d = (outstanding_q == '0) ? ST_IDLE : ST_FLUSH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    base_d        = base_q;
    index_d       = index_q;
    remaining_d   = remaining_q;
    address_d     = address_q;
    req_d         = 1'b0;
    done_d        = 1'b0;
    outstanding_d = outstanding_q;
    if (start_ok_s) begin
      base_d      = base_address;
      index_d     = '0;
      remaining_d = frame_length;
      done_d      = (frame_length == '0);
    end else if (issue_s) begin
      address_d   = base_q + index_q;
      req_d       = 1'b1;
      index_d     = index_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end else if (drain_end_s && !abort) begin
      done_d = 1'b1;
`ifdef FRAME_FETCH_LOOP_EN
      index_d     = '0;
      remaining_d = len_q;
`endif
    end else begin
      done_d = 1'b0;
    end
    case ({issue_s, ret_ok_s})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q        <= '0;
      index_q       <= '0;
      remaining_q   <= '0;
      address_q     <= '0;
      outstanding_q <= '0;
      req_q         <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      base_q        <= base_d;
      index_q       <= index_d;
      remaining_q   <= remaining_d;
      address_q     <= address_d;
      outstanding_q <= outstanding_d;
      req_q         <= req_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

`ifdef FRAME_FETCH_LOOP_EN
  // frame length kept for reloading each refresh pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
    end else if (start_ok_s) begin
      len_q <= frame_length;
    end else begin
      len_q <= len_q;
    end
  end
`endif

  byte_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(DATA_WIDTH), .CW(CW)) u_ret_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (state_q == ST_FLUSH),
    .push_i      (ret_ok_s && (state_q != ST_FLUSH)),
    .push_data_i (data_out),
    .pop_i       (pop_s),
    .head_data_o (pixel_data),
    .empty_o     (buf_empty_s),
    .count_o     (buf_count_s)
  );

  assign address       = address_q;
  assign data_in_ready = req_q;
  assign wr            = 1'b0;
  assign data_in       = '0;
  assign pixel_valid   = pixel_valid_s;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: randomized bench for frame_fetch against a counting model of
// requests, in-order arbiter returns and downstream pops.
module tb_frame_fetch;

  localparam int AW     = 25;
  localparam int DEPTH  = 8;
  localparam int BUDGET = 2000;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_address;
  logic [AW-1:0] frame_length;
  logic [AW-1:0] address;
  logic          wr;
  logic [7:0]    data_in;
  logic          data_in_ready;
  logic          fifo_full;
  logic [7:0]    data_out;
  logic          data_out_ready;
  logic [7:0]    pixel_data;
  logic          pixel_valid;
  logic          pixel_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  frame_fetch #(.ADDRESS_WIDTH(AW), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .base_address   (base_address),
    .frame_length   (frame_length),
    .address        (address),
    .wr             (wr),
    .data_in        (data_in),
    .data_in_ready  (data_in_ready),
    .fifo_full      (fifo_full),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .pixel_data     (pixel_data),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // memory image the arbiter model serves
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[24:18]} ^ 8'h3C;
  endfunction

  // rdy_mode: 0 always, 1 random, 2 held low until cycle 60, 3 never
  // ff_mode: 0 never full, 1 alternate cycles, 2 random, 3 full once 5 requests seen
  task automatic run_frame(input logic [AW-1:0] base, input int len, input int lat_lo,
                           input int lat_hi, input int rdy_mode, input int ff_mode,
                           input int abort_mode, input int loops);
    int            n_req, n_ret, n_pop, n_done, cyc, abort_cyc, last_pop_cyc, lat;
    int            due_q[$];
    logic [AW-1:0] ret_addr_q[$];
    logic [AW-1:0] exp_addr;
    bit            ff_prev, aborted, flushing, exp_pv;
    n_req = 0; n_ret = 0; n_pop = 0; n_done = 0;
    abort_cyc = 0; last_pop_cyc = -10;
    ff_prev = 1'b0; aborted = 1'b0; flushing = 1'b0;
    base_address = base;
    frame_length = AW'(len);
    start = 1'b1;
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      flushing = aborted && (cyc > abort_cyc);
      if (cyc == 0) begin
        check_eq("busy_after_start", busy, 1);
        check_eq("no_early_req", data_in_ready, 0);
      end
      if (data_in_ready) begin
        exp_addr = base + AW'(n_req % len);
        check_eq("req_addr", address, exp_addr);
        check_eq("req_while_full", ff_prev, 0);
        if (flushing) check_eq("req_after_abort", data_in_ready, 0);
        if (loops == 0) check_eq("req_within_len", n_req < len, 1);
        n_req++;
        check_eq("credit_limit", (n_req - n_pop) <= DEPTH, 1);
        if (abort_mode != 0) lat = (n_req <= 2) ? 2 : 20;
        else lat = $urandom_range(lat_hi, lat_lo);
        due_q.push_back(cyc + lat);
        ret_addr_q.push_back(address);
      end
      if (done) begin
        check_eq("done_timing", cyc, last_pop_cyc + 1);
        check_eq("done_frame_bytes", n_pop, (n_done + 1) * len);
        n_done++;
      end
      if (!aborted && loops == 0 && abort_mode == 0 && n_done >= 1 && !busy) break;
      if (flushing && !busy) break;
      exp_pv = !flushing && ((n_ret - n_pop) > 0);
      check_eq("pixel_valid", pixel_valid, exp_pv);
      if (rdy_mode == 2 && cyc == 50) check_eq("stall_reqs", n_req, DEPTH);
      case (rdy_mode)
        0:       pixel_ready = 1'b1;
        1:       pixel_ready = 1'($urandom_range(1, 0));
        2:       pixel_ready = (cyc >= 60);
        default: pixel_ready = 1'b0;
      endcase
      if (pixel_valid && pixel_ready) begin
        check_eq("pixel_data", pixel_data, mem_byte(base + AW'(n_pop % len)));
        n_pop++;
        last_pop_cyc = cyc;
      end
      data_out_ready = 1'b0;
      data_out       = 8'($urandom);
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        data_out_ready = 1'b1;
        data_out       = mem_byte(ret_addr_q[0]);
        void'(due_q.pop_front());
        void'(ret_addr_q.pop_front());
        n_ret++;
      end
      case (ff_mode)
        0:       fifo_full = 1'b0;
        1:       fifo_full = cyc[0];
        2:       fifo_full = 1'($urandom_range(1, 0));
        default: fifo_full = (n_req >= 5);
      endcase
      ff_prev = fifo_full;
      abort = 1'b0;
      if (!aborted && ((abort_mode != 0 && n_req == 5 && n_ret == 2) ||
                       (loops > 0 && n_done >= loops))) begin
        abort     = 1'b1;
        aborted   = 1'b1;
        abort_cyc = cyc;
      end
    end
    check_eq("in_budget", cyc < BUDGET, 1);
    start = 1'b0; abort = 1'b0; data_out_ready = 1'b0; fifo_full = 1'b0; pixel_ready = 1'b0;
    check_eq("abort_taken", aborted, (abort_mode != 0) || (loops > 0));
    if (aborted) begin
      check_eq("abort_done_count", n_done, loops);
      check_eq("flush_returns", n_ret, n_req);
    end else begin
      check_eq("req_total", n_req, len);
      check_eq("pix_total", n_pop, len);
      check_eq("done_count", n_done, 1);
    end
    check_eq("busy_end", busy, 0);
    @(posedge clk); #1;
    check_eq("done_pulse", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_address = '0; frame_length = '0;
    fifo_full = 1'b0; data_out = '0; data_out_ready = 1'b0; pixel_ready = 1'b0;
    #1;
    check_eq("rst_address", address, 0);
    check_eq("rst_req", data_in_ready, 0);
    check_eq("rst_pixel_data", pixel_data, 0);
    check_eq("rst_pixel_valid", pixel_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("wr_tied", wr, 0);
    check_eq("data_in_tied", data_in, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // stray returns with nothing outstanding are dropped
    data_out_ready = 1'b1; data_out = 8'hEE;
    repeat (2) @(posedge clk);
    #1 data_out_ready = 1'b0;
    check_eq("stray_dropped", pixel_valid, 0);
    check_eq("stray_busy", busy, 0);

    // zero-length start
    base_address = 25'h0000123; frame_length = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("len0_done", done, 1);
    check_eq("len0_busy", busy, 0);
    @(posedge clk); #1;
    check_eq("len0_pulse", done, 0);
    check_eq("len0_no_req", data_in_ready, 0);

`ifdef FRAME_FETCH_LOOP_EN
    run_frame(25'h0000040, 3, 1, 3, 1, 0, 0, 3);
    run_frame(25'h1FFFFFF, 3, 1, 2, 0, 2, 0, 2);
`else
    run_frame(25'h0000100, 4, 2, 2, 0, 0, 0, 0);
    run_frame(25'h0002000, 20, 1, 3, 2, 0, 0, 0);
    run_frame(25'h0000777, 10, 1, 3, 0, 1, 0, 0);
    run_frame(25'h1FFFFFE, 4, 1, 4, 0, 0, 0, 0);
    run_frame(25'h0000300, 20, 1, 1, 3, 3, 1, 0);
    for (int k = 0; k < 4; k++) begin
      run_frame(AW'($urandom), $urandom_range(24, 1), 1, 4, 1, 2, 0, 0);
    end
    run_frame(25'h1FFFFF8, 16, 1, 5, 1, 2, 0, 0);
`endif

    // reset in the middle of a frame discards everything
    base_address = 25'h0000500; frame_length = 25'd10; start = 1'b1;
    repeat (4) begin
      @(posedge clk); #1 start = 1'b0;
    end
    check_eq("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_req", data_in_ready, 0);
    check_eq("mid_rst_address", address, 0);
    check_eq("mid_rst_pixel_valid", pixel_valid, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    data_out_ready = 1'b1; data_out = 8'h77;
    @(posedge clk); #1 data_out_ready = 1'b0;
    check_eq("late_return_dropped", pixel_valid, 0);
    check_eq("late_return_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
